// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial AND/OR/ADD/SUB/SLT ALU, one bit per cycle, LSB first; define ALU_SERIAL_OVF_EN to add the ovf output and a signed SLT
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef ALU_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             err
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_SLT = 6'b101010;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, shift_q, shift_d, result_q, result_d, shifted;
  logic [5:0]       sig_q, sig_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, done_q, done_d, err_q, err_d;
  logic             legal, is_logic, a_bit, b_bit, sum, cout, slice, last, less;
`ifdef ALU_SERIAL_OVF_EN
  logic             ovf_q, ovf_d, msb_ovf;
`endif
  // shared 1-bit slice on bit cnt_q of the captured operands; SUB/SLT invert B with carry-in 1
  always_comb begin
    legal    = Signal inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
    is_logic = (sig_q == OP_AND) || (sig_q == OP_OR);
    a_bit    = a_q[cnt_q];
    b_bit    = b_q[cnt_q] ^ sig_q[1];
    sum      = a_bit ^ b_bit ^ carry_q;
    cout     = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
    slice    = (sig_q == OP_AND) ? (a_bit & b_bit) : (sig_q == OP_OR) ? (a_bit | b_bit) : sum;
    last     = cnt_q == CW'(WIDTH - 1);
    shifted  = shift_q;
    shifted[cnt_q] = slice;
`ifdef ALU_SERIAL_OVF_EN
    msb_ovf  = ((sig_q == OP_ADD) || (sig_q == OP_SUB)) && (carry_q ^ cout);
    less     = sum ^ carry_q ^ cout;
`else
    less     = sum;
`endif
  end
  // IDLE/RUN/FIN sequencing; done, err and result are registered on the edge entering FIN
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    shift_d  = shift_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef ALU_SERIAL_OVF_EN
    ovf_d    = 1'b0;
`endif
    case (state_q)
      IDLE: if (start) begin
        a_d      = A;
        b_d      = B;
        sig_d    = Signal;
        cnt_d    = '0;
        carry_d  = Signal[1];
        shift_d  = '0;
        state_d  = legal ? RUN : FIN;
        done_d   = !legal;
        err_d    = !legal;
        result_d = legal ? result_q : '0;
      end
      RUN: begin
        shift_d = shifted;
        carry_d = !is_logic && cout;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          state_d  = FIN;
          done_d   = 1'b1;
          result_d = (sig_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, less} : shifted;
`ifdef ALU_SERIAL_OVF_EN
          ovf_d    = msb_ovf;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sig_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      shift_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      shift_q  <= shift_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef ALU_SERIAL_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end
  assign ready  = state_q == IDLE;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
`ifdef ALU_SERIAL_OVF_EN
  assign ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: directed vectors for alu_serial_ctrl checked against a cycle-level behavioural model
module tb_alu_serial_ctrl;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [5:0]  Signal = '0;
  logic [31:0] A = '0, B = '0;
  logic        ready, done, err;
  logic [31:0] result;
`ifdef ALU_SERIAL_OVF_EN
  logic        ovf;
`endif
  int n_cmp = 0, n_bad = 0;
  logic chk_en = 1'b0;
  int m_busy = 0;
  logic m_done = 1'b0, m_err = 1'b0, m_ovf = 1'b0, m_ready = 1'b1;
  logic [31:0] m_res = '0, p_res, sum_v, diff_v;
  logic p_ovf;

  alu_serial_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .Signal(Signal), .A(A), .B(B),
    .ready(ready), .done(done), .result(result),
`ifdef ALU_SERIAL_OVF_EN
    .ovf(ovf),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: an accepted legal op finishes 32 edges later, an illegal one on the next edge; done lasts one cycle
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 1'b0; m_err = 1'b0; m_ovf = 1'b0; m_res = '0;
    end else if (m_done) begin
      m_done = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_done = 1'b1; m_res = p_res; m_ovf = p_ovf;
      end
    end else if (start) begin
      sum_v = A + B;
      diff_v = A - B;
      p_ovf = 1'b0;
      m_busy = 32;
      case (Signal)
        6'b100100: p_res = A & B;
        6'b100101: p_res = A | B;
        6'b100000: begin p_res = sum_v; p_ovf = (A[31] == B[31]) && (sum_v[31] != A[31]); end
        6'b100010: begin p_res = diff_v; p_ovf = (A[31] != B[31]) && (diff_v[31] != A[31]); end
`ifdef ALU_SERIAL_OVF_EN
        6'b101010: p_res = {31'b0, $signed(A) < $signed(B)};
`else
        6'b101010: p_res = {31'b0, diff_v[31]};
`endif
        default: begin
          m_busy = 0; m_done = 1'b1; m_err = 1'b1; m_res = '0;
        end
      endcase
    end
    m_ready = !m_done && (m_busy == 0);
  end

  always @(negedge clk) if (chk_en) begin
    chk("ready", 64'(ready), 64'(m_ready));
    chk("done", 64'(done), 64'(m_done));
    chk("err", 64'(err), 64'(m_err));
    chk("result", 64'(result), 64'(m_res));
`ifdef ALU_SERIAL_OVF_EN
    chk("ovf", 64'(ovf), 64'(m_ovf));
`endif
  end

  task automatic run_op(input string name, input logic [5:0] s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic exp_err, input int lat);
    int n;
    @(negedge clk);
    start = 1'b1; Signal = s; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(lat));
    chk({name, "_result"}, 64'(result), 64'(exp));
    chk({name, "_err"}, 64'(err), 64'(exp_err));
  endtask

  initial begin
    int dones;
    repeat (2) @(negedge clk);
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    run_op("add", 6'b100000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 33);
    run_op("sub_wrap", 6'b100010, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("add_wrap", 6'b100000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 33);
    run_op("and", 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 33);
    run_op("or", 6'b100101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 33);
    run_op("slt_lt", 6'b101010, 32'd3, 32'd7, 32'd1, 1'b0, 33);
    run_op("slt_ge", 6'b101010, 32'd7, 32'd3, 32'd0, 1'b0, 33);
`ifdef ALU_SERIAL_OVF_EN
    run_op("slt_signed", 6'b101010, 32'h8000_0000, 32'h1, 32'd1, 1'b0, 33);
    chk("slt_signed_ovf", 64'(ovf), 64'd0);
    run_op("sub_ovf", 6'b100010, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 33);
    chk("sub_ovf_ovf", 64'(ovf), 64'd1);
`else
    run_op("slt_unsigned_msb", 6'b101010, 32'h8000_0000, 32'h1, 32'd0, 1'b0, 33);
`endif
    run_op("illegal", 6'b000000, 32'h1234_5678, 32'h1, 32'h0, 1'b1, 1);
    run_op("illegal_3f", 6'b111111, 32'h1, 32'h1, 32'h0, 1'b1, 1);
    @(negedge clk);
    start = 1'b1; Signal = 6'b100000; A = 32'd10; B = 32'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; Signal = 6'b100010; A = 32'd99; B = 32'd1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        dones++;
        chk("midrun_start_result", 64'(result), 64'd30);
      end
      @(negedge clk);
    end
    chk("midrun_start_done_count", 64'(dones), 64'd1);
    @(negedge clk);
    start = 1'b1; Signal = 6'b100000; A = 32'd1; B = 32'd2;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 11; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("rst_no_done", 64'(dones), 64'd0);
    run_op("add_after_rst", 6'b100000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 33);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
